// File: rtl/alu_8bit.sv
// alu_8bit -- 8-bit registered ALU for the execute stage.
//
// Purpose:
//   Two 8-bit operands and a 5-bit opcode {s4,s3,s2,s1,s0} produce an 8-bit
//   result and a carry/borrow/shift-out bit. Both outputs are registered,
//   giving one clock of latency with a new operation accepted every cycle.
//   The registered carry (cout) is also the carry-in for ADC and SBB.
//
// Ports:
//   clk      in   1  system clock, rising edge
//   rst      in   1  synchronous, active-high reset (o=00, cout=0)
//   a        in   8  operand A
//   b        in   8  operand B
//   s0..s4   in   1  opcode bits, s0 = LSB, s4 = MSB
//   o        out  8  registered result
//   cout     out  1  registered carry/borrow/shift-out, stored carry flag
//
// Configuration:
//   ALU_MUL_EN  when defined, opcodes 26 (MULLO) and 27 (MULHI) use an 8x8
//               multiplier; when undefined no multiplier is built and both
//               opcodes return o=00, cout=0.

module alu_8bit (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       s0,
  input  logic       s1,
  input  logic       s2,
  input  logic       s3,
  input  logic       s4,
  output logic [7:0] o,
  output logic       cout
);

  typedef enum logic [4:0] {
    OP_ADD   = 5'd0,  OP_SUB   = 5'd1,  OP_INC   = 5'd2,  OP_DEC   = 5'd3,
    OP_AND   = 5'd4,  OP_OR    = 5'd5,  OP_XOR   = 5'd6,  OP_NOT   = 5'd7,
    OP_NAND  = 5'd8,  OP_NOR   = 5'd9,  OP_XNOR  = 5'd10, OP_PASSA = 5'd11,
    OP_SHL   = 5'd12, OP_SHR   = 5'd13, OP_ROL   = 5'd14, OP_ROR   = 5'd15,
    OP_ASR   = 5'd16, OP_PASSB = 5'd17, OP_NEG   = 5'd18, OP_CMPEQ = 5'd19,
    OP_SLTU  = 5'd20, OP_ADC   = 5'd21, OP_SBB   = 5'd22, OP_SWAP  = 5'd23,
    OP_SHLV  = 5'd24, OP_SHRV  = 5'd25, OP_MULLO = 5'd26, OP_MULHI = 5'd27,
    OP_MAXU  = 5'd28, OP_MINU  = 5'd29, OP_CLR   = 5'd30, OP_SET   = 5'd31
  } op_e;

  op_e         op;
  logic [7:0]  o_q, o_d;
  logic        cout_q, cout_d;

  // Shared 9-bit adder/subtractor results; bit 8 is carry (add) or borrow
  // (subtract, from two's-complement wraparound of the zero-extended values).
  logic [8:0]  add_sum, sub_dif, adc_sum, sbb_dif;
  // Variable shifts are done in a 16-bit window so the last bit shifted out
  // lands at a fixed position (bit 8 for left, bit 7 for right); a shift of
  // zero leaves that position zero.
  logic [15:0] shlv_w, shrv_w;
  logic [15:0] prod;

  assign op      = op_e'({s4, s3, s2, s1, s0});
  assign add_sum = {1'b0, a} + {1'b0, b};
  assign sub_dif = {1'b0, a} - {1'b0, b};
  assign adc_sum = {1'b0, a} + {1'b0, b} + {8'd0, cout_q};
  assign sbb_dif = {1'b0, a} - {1'b0, b} - {8'd0, cout_q};
  assign shlv_w  = {8'd0, a} << b[2:0];
  assign shrv_w  = {a, 8'd0} >> b[2:0];

`ifdef ALU_MUL_EN
  assign prod = {8'd0, a} * {8'd0, b};
`else
  assign prod = 16'd0;
`endif

  always_comb begin
    o_d    = 8'h00;
    cout_d = 1'b0;
    case (op)
      OP_ADD:   {cout_d, o_d} = add_sum;
      OP_SUB:   {cout_d, o_d} = sub_dif;
      OP_INC:   {cout_d, o_d} = {1'b0, a} + 9'd1;
      OP_DEC:   {cout_d, o_d} = {1'b0, a} - 9'd1;
      OP_AND:   o_d = a & b;
      OP_OR:    o_d = a | b;
      OP_XOR:   o_d = a ^ b;
      OP_NOT:   o_d = ~a;
      OP_NAND:  o_d = ~(a & b);
      OP_NOR:   o_d = ~(a | b);
      OP_XNOR:  o_d = ~(a ^ b);
      OP_PASSA: o_d = a;
      OP_SHL:   begin o_d = {a[6:0], 1'b0}; cout_d = a[7]; end
      OP_SHR:   begin o_d = {1'b0, a[7:1]}; cout_d = a[0]; end
      OP_ROL:   begin o_d = {a[6:0], a[7]}; cout_d = a[7]; end
      OP_ROR:   begin o_d = {a[0], a[7:1]}; cout_d = a[0]; end
      OP_ASR:   begin o_d = {a[7], a[7:1]}; cout_d = a[0]; end
      OP_PASSB: o_d = b;
      OP_NEG:   begin o_d = 8'h00 - a; cout_d = (a != 8'h00); end
      OP_CMPEQ: o_d = (a == b) ? 8'h01 : 8'h00;
      OP_SLTU:  o_d = (a < b) ? 8'h01 : 8'h00;
      OP_ADC:   {cout_d, o_d} = adc_sum;
      OP_SBB:   {cout_d, o_d} = sbb_dif;
      OP_SWAP:  o_d = {a[3:0], a[7:4]};
      OP_SHLV:  begin o_d = shlv_w[7:0];  cout_d = shlv_w[8]; end
      OP_SHRV:  begin o_d = shrv_w[15:8]; cout_d = shrv_w[7]; end
      OP_MULLO: begin o_d = prod[7:0];    cout_d = (prod[15:8] != 8'h00); end
      OP_MULHI: o_d = prod[15:8];
      OP_MAXU:  o_d = (a > b) ? a : b;
      OP_MINU:  o_d = (a < b) ? a : b;
      OP_CLR:   o_d = 8'h00;
      OP_SET:   o_d = 8'hFF;
      default:  begin o_d = 8'h00; cout_d = 1'b0; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_q    <= 8'h00;
      cout_q <= 1'b0;
    end else begin
      o_q    <= o_d;
      cout_q <= cout_d;
    end
  end

  assign o    = o_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_alu_8bit.sv
// tb_alu_8bit -- scoreboard bench for alu_8bit.
// Stimulus issues one directed vector per cycle and pushes its hand-computed
// result into a queue; a monitor pops and compares one cycle later.

module tb_alu_8bit;

  logic       clk;
  logic       rst;
  logic [7:0] a, b;
  logic [4:0] op;
  logic [7:0] o;
  logic       cout;

  logic       issue;
  logic       vld;
  logic [8:0] exp_q[$];
  logic [8:0] exp_v;
  int         n_cmp;
  int         n_bad;

  alu_8bit dut (
    .clk  (clk),
    .rst  (rst),
    .a    (a),
    .b    (b),
    .s0   (op[0]),
    .s1   (op[1]),
    .s2   (op[2]),
    .s3   (op[3]),
    .s4   (op[4]),
    .o    (o),
    .cout (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Marks the cycle in which the DUT output reflects an issued vector.
  always @(posedge clk) vld <= issue;

  always @(negedge clk) begin
    if (vld) begin
      n_cmp = n_cmp + 1;
      if (exp_q.size() == 0) begin
        n_bad = n_bad + 1;
        $display("FAIL scoreboard_empty: got o=%02h cout=%0b, no expected entry", o, cout);
      end else begin
        exp_v = exp_q.pop_front();
        if ({cout, o} !== exp_v) begin
          n_bad = n_bad + 1;
          $display("FAIL vec%0d: got o=%02h cout=%0b, expected o=%02h cout=%0b",
                   n_cmp, o, cout, exp_v[7:0], exp_v[8]);
        end
      end
    end
  end

  task automatic issue_vec(input logic r, input logic [7:0] av, input logic [7:0] bv,
                           input logic [4:0] opv, input logic [7:0] eo, input logic ec);
    @(posedge clk);
    #1;
    rst   = r;
    a     = av;
    b     = bv;
    op    = opv;
    issue = 1'b1;
    exp_q.push_back({ec, eo});
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    vld   = 1'b0;
    issue = 1'b0;
    rst   = 1'b1;
    a     = 8'h00;
    b     = 8'h00;
    op    = 5'd0;

    // reset wins over a concurrent op
    issue_vec(1'b1, 8'hE0, 8'h03, 5'd0,  8'h00, 1'b0);
    issue_vec(1'b0, 8'hE0, 8'h03, 5'd0,  8'hE3, 1'b0);
    issue_vec(1'b0, 8'hE0, 8'h03, 5'd12, 8'hC0, 1'b1);
    issue_vec(1'b0, 8'hE0, 8'h03, 5'd1,  8'hDD, 1'b0);
    issue_vec(1'b0, 8'hFF, 8'h01, 5'd0,  8'h00, 1'b1);
    issue_vec(1'b0, 8'h00, 8'h00, 5'd21, 8'h01, 1'b0);
    issue_vec(1'b0, 8'h00, 8'h01, 5'd1,  8'hFF, 1'b1);
    issue_vec(1'b0, 8'h05, 8'h02, 5'd22, 8'h02, 1'b0);
    issue_vec(1'b0, 8'h81, 8'h00, 5'd14, 8'h03, 1'b1);
    issue_vec(1'b0, 8'h81, 8'h00, 5'd15, 8'hC0, 1'b1);
    issue_vec(1'b0, 8'h81, 8'h00, 5'd16, 8'hC0, 1'b1);
    issue_vec(1'b0, 8'h81, 8'h03, 5'd25, 8'h10, 1'b0);
`ifdef ALU_MUL_EN
    issue_vec(1'b0, 8'h10, 8'h20, 5'd26, 8'h00, 1'b1);
    issue_vec(1'b0, 8'h10, 8'h20, 5'd27, 8'h02, 1'b0);
`else
    issue_vec(1'b0, 8'h10, 8'h20, 5'd26, 8'h00, 1'b0);
    issue_vec(1'b0, 8'h10, 8'h20, 5'd27, 8'h00, 1'b0);
`endif
    // carry set, then reset clears it: ADC right after reset uses carry-in 0
    issue_vec(1'b0, 8'hFF, 8'h01, 5'd0,  8'h00, 1'b1);
    issue_vec(1'b1, 8'hFF, 8'hFF, 5'd21, 8'h00, 1'b0);
    issue_vec(1'b0, 8'hFF, 8'h01, 5'd21, 8'h00, 1'b1);
    issue_vec(1'b0, 8'h10, 8'h20, 5'd21, 8'h31, 1'b0);
    issue_vec(1'b0, 8'hFF, 8'h00, 5'd2,  8'h00, 1'b1);
    issue_vec(1'b0, 8'h00, 8'h00, 5'd3,  8'hFF, 1'b1);
    issue_vec(1'b0, 8'h01, 8'h00, 5'd18, 8'hFF, 1'b1);
    issue_vec(1'b0, 8'h00, 8'h00, 5'd18, 8'h00, 1'b0);
    issue_vec(1'b0, 8'h5A, 8'h5A, 5'd19, 8'h01, 1'b0);
    issue_vec(1'b0, 8'h03, 8'h04, 5'd20, 8'h01, 1'b0);
    issue_vec(1'b0, 8'hA5, 8'h00, 5'd23, 8'h5A, 1'b0);
    issue_vec(1'b0, 8'h81, 8'h01, 5'd24, 8'h02, 1'b1);
    issue_vec(1'b0, 8'h81, 8'h00, 5'd24, 8'h81, 1'b0);
    issue_vec(1'b0, 8'h30, 8'h70, 5'd28, 8'h70, 1'b0);
    issue_vec(1'b0, 8'h30, 8'h70, 5'd29, 8'h30, 1'b0);
    issue_vec(1'b0, 8'hF0, 8'h3C, 5'd4,  8'h30, 1'b0);
    issue_vec(1'b0, 8'hF0, 8'h3C, 5'd5,  8'hFC, 1'b0);
    issue_vec(1'b0, 8'hF0, 8'h3C, 5'd6,  8'hCC, 1'b0);
    issue_vec(1'b0, 8'hF0, 8'h3C, 5'd7,  8'h0F, 1'b0);
    issue_vec(1'b0, 8'hF0, 8'h3C, 5'd8,  8'hCF, 1'b0);
    issue_vec(1'b0, 8'hF0, 8'h3C, 5'd9,  8'h03, 1'b0);
    issue_vec(1'b0, 8'hF0, 8'h3C, 5'd10, 8'h33, 1'b0);
    issue_vec(1'b0, 8'hF0, 8'h3C, 5'd11, 8'hF0, 1'b0);
    issue_vec(1'b0, 8'hF0, 8'h3C, 5'd17, 8'h3C, 1'b0);
    issue_vec(1'b0, 8'h81, 8'h00, 5'd13, 8'h40, 1'b1);
    issue_vec(1'b0, 8'h12, 8'h34, 5'd31, 8'hFF, 1'b0);
    issue_vec(1'b0, 8'h12, 8'h34, 5'd30, 8'h00, 1'b0);

    @(posedge clk);
    #1;
    issue = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_bad = n_bad + 1;
      $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
